// File: rtl/inst_loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time instruction loader.
//   loader_state_t : loader FSM states
//   LEN_BYTES      : bytes in the little-endian word-count header
//   WORD_BYTES     : bytes per instruction word
package loader_pkg;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: host byte link, instruction-memory write port and processor
// control/status of the loader, bundled as one interface.
//   rx_valid/rx_data/rx_ready : byte stream from host (master drives valid/data)
//   imem_we/imem_waddr/imem_wdata : instruction-memory write port (loader drives)
//   cpu_reset/done/error      : processor reset and load status (loader drives)
// Modports: slave = loader side, master = host/memory/system side.
interface inst_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/inst_loader_word_packer.sv
// word_packer: packs accepted bytes into a 32-bit little-endian word.
//   clock, reset : clock, synchronous active-high reset
//   byte_valid   : a byte is accepted this cycle
//   byte_in      : the accepted byte
//   word         : assembled word including the current byte (valid with word_valid)
//   word_valid   : combinational, high in the cycle the 4th byte is accepted
// The outputs are combinational so the caller can act on the completed word on
// the same edge that accepts its last byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    // New bytes enter at the top, so the first byte lands in [7:0] after four.
    assign word       = {byte_in, shreg[31:8]};
    assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= word;
            cnt   <= cnt + 2'd1;   // wraps 3 -> 0 at each word boundary
        end
    end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader. Receives a framed byte stream
// (4-byte LE word count N, N LE words, 1 XOR checksum byte), writes the words
// to instruction memory at byte addresses 0,4,8,... and releases the processor
// reset only after the checksum matches.
//   DEPTH_WORDS : instruction memory capacity in words (largest legal N)
//   clock       : system clock
//   reset       : synchronous active-high reset
//   bus         : inst_loader_if.slave (rx stream, imem write port, status)
module inst_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clock,
    input  logic          reset,
    inst_loader_if.slave  bus
);

    loader_state_t state;
    logic [31:0]   word_idx;
    logic [31:0]   len;
    logic [7:0]    csum;
    logic          accept;
    logic          pack_valid;
    logic [31:0]   word;
    logic          word_valid;

    assign bus.rx_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept        = bus.rx_valid && bus.rx_ready;
    assign bus.cpu_reset = (state != S_RUN);
    assign bus.done      = (state == S_RUN);
    assign bus.error     = (state == S_ERR);

    // The checksum byte is not a packed byte; only header and data feed the packer.
    assign pack_valid = accept && ((state == S_LEN) || (state == S_DATA));

    word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (pack_valid),
        .byte_in    (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_LEN;
            word_idx       <= '0;
            len            <= '0;
            csum           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (pack_valid) begin
                csum <= csum ^ bus.rx_data;
            end
            case (state)
                S_LEN: begin
                    if (word_valid) begin
                        len <= word;
                        if (word > 32'(DEPTH_WORDS)) begin
                            state <= S_ERR;
                        end else if (word == 32'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_waddr <= word_idx << 2;
                        bus.imem_wdata <= word;
                        word_idx       <= word_idx + 32'd1;
                        if (word_idx == len - 32'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        state <= (bus.rx_data == csum) ? S_RUN : S_ERR;
                    end
                end
                default: ;   // S_RUN and S_ERR hold until reset
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    inst_loader_if bus ();

    inst_loader #(.DEPTH_WORDS(1024)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, filled by the monitor only.
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cnt = 0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = bus.imem_waddr;
            wr_data[wr_cnt] = bus.imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    logic [7:0] normal_stream [0:12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                          8'h93, 8'h00, 8'h50, 8'h00,
                                          8'h13, 8'h81, 8'h10, 8'h00, 8'h43};

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_normal(input int gap, input logic [7:0] last);
        for (int i = 0; i < 13; i++) begin
            send_byte((i == 12) ? last : normal_stream[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_two_writes(input string tag, input int base);
        tests++;
        if (wr_cnt - base !== 2) begin
            fails++;
            $display("FAIL %s write count: got %0d expected 2", tag, wr_cnt - base);
        end else begin
            tests++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00500093) begin
                fails++;
                $display("FAIL %s word0: got addr %h data %h expected 0 00500093",
                         tag, wr_addr[base], wr_data[base]);
            end
            tests++;
            if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00108113) begin
                fails++;
                $display("FAIL %s word1: got addr %h data %h expected 4 00108113",
                         tag, wr_addr[base+1], wr_data[base+1]);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic e_rdy, input logic e_cpu,
                                input logic e_done, input logic e_err);
        tests++;
        if ({bus.rx_ready, bus.cpu_reset, bus.done, bus.error} !== {e_rdy, e_cpu, e_done, e_err}) begin
            fails++;
            $display("FAIL %s status rdy/cpu_rst/done/err: got %b%b%b%b expected %b%b%b%b", tag,
                     bus.rx_ready, bus.cpu_reset, bus.done, bus.error, e_rdy, e_cpu, e_done, e_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== 65'd0) begin
            fails++;
            $display("FAIL reset imem: got we %b addr %h data %h expected 0 0 0",
                     bus.imem_we, bus.imem_waddr, bus.imem_wdata);
        end
    endtask

    task automatic test_normal();
        int base;
        do_reset();
        base = wr_cnt;
        send_normal(0, 8'h43);
        @(negedge clk);
        check_status("normal", 1'b0, 1'b0, 1'b1, 1'b0);
        check_two_writes("normal", base);
        idle(3);
        check_status("normal_sticky", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_zero_length();
        int base;
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        @(negedge clk);
        check_status("zero_len", 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (wr_cnt != base) begin
            fails++;
            $display("FAIL zero_len writes: got %0d expected 0", wr_cnt - base);
        end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        check_status("oversize", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        @(negedge clk);
        check_status("oversize_after", 1'b0, 1'b1, 1'b0, 1'b1);
        tests++;
        if (wr_cnt != base) begin
            fails++;
            $display("FAIL oversize writes: got %0d expected 0", wr_cnt - base);
        end
    endtask

    task automatic test_max_length_accepted();
        // N = 1024 is legal: loader must move on to data collection.
        do_reset();
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        check_status("len_1024", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        int base;
        do_reset();
        base = wr_cnt;
        send_normal(0, 8'h44);
        @(negedge clk);
        check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1);
        check_two_writes("bad_csum", base);
    endtask

    task automatic test_flow_control();
        int base;
        do_reset();
        base = wr_cnt;
        send_normal(3, 8'h43);
        @(negedge clk);
        check_status("flow", 1'b0, 1'b0, 1'b1, 1'b0);
        check_two_writes("flow", base);
    endtask

    task automatic test_reset_mid_load();
        int base;
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(normal_stream[i]);
        do_reset();
        @(negedge clk);
        check_status("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== 65'd0) begin
            fails++;
            $display("FAIL mid_reset imem: got we %b addr %h data %h expected 0 0 0",
                     bus.imem_we, bus.imem_waddr, bus.imem_wdata);
        end
        base = wr_cnt;
        send_normal(0, 8'h43);
        @(negedge clk);
        check_status("reload", 1'b0, 1'b0, 1'b1, 1'b0);
        check_two_writes("reload", base);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_normal();
        test_zero_length();
        test_oversize();
        test_max_length_accepted();
        test_bad_checksum();
        test_flow_control();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader: the write side of the instruction memory that `single_cycle_processor` only reads. It receives a framed byte stream from a host link, packs bytes into 32-bit little-endian instruction words, and drives sequential writes into instruction memory. While loading it holds the processor in reset, and it releases the processor only after a valid checksum.

## Interface
- `DEPTH_WORDS`, default 1024: instruction memory capacity in words; the largest legal word count.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  incoming stream byte.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on a cycle with `rx_valid && rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  32  byte address of the write, word-aligned (`[1:0]`=0).
- `imem_wdata`  out  32  instruction word to write.
- `cpu_reset`  out  1  reset to the processor; high until the load succeeds.
- `done`  out  1  load completed and checksum matched; sticky.
- `error`  out  1  length out of range or checksum mismatch; sticky.

## Operation
- Frame format, in order:
  - 4 bytes: word count N, little-endian.
  - N×4 bytes: instruction words, little-endian, stored at addresses 0, 4, 8, …
  - 1 byte: checksum, equal to the XOR of every preceding frame byte (length bytes included).
- FSM states:
  - S_LEN: collect 4 length bytes. After the 4th byte:
    - N > DEPTH_WORDS → S_ERR.
    - N == 0 → S_CSUM.
    - otherwise → S_DATA.
  - S_DATA: collect words. Each 4th byte issues one memory write and increments the word index. After word N-1 is written → S_CSUM.
  - S_CSUM: accept 1 byte. If it equals the running XOR → S_RUN, else → S_ERR.
  - S_RUN: `rx_ready`=0, `cpu_reset`=0, `done`=1. Remains here until `reset`.
  - S_ERR: `rx_ready`=0, `cpu_reset`=1, `error`=1. Remains here until `reset`.
- `rx_ready`=1 in S_LEN, S_DATA and S_CSUM. Bytes are accepted back-to-back at one per cycle with no gaps required. A cycle with `rx_valid`=0 leaves all state unchanged.
- Byte counter is 2 bits and wraps 3→0 at each word boundary. Word index is 32 bits wide. `imem_waddr` = word_index << 2.
- The running XOR is updated on every accepted byte except the checksum byte itself.
- Memory contents are never cleared by this block. After an error or a reset mid-load, partial contents remain until the next successful load overwrites them.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - state S_LEN; `rx_ready`=1; `cpu_reset`=1.
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `done`=0, `error`=0; byte counter, word index, length and XOR all 0.
- Write latency: `imem_we`, `imem_waddr` and `imem_wdata` are registered.
  - The strobe is high for exactly the one cycle after the edge that accepted the word's 4th byte.
  - Address and data stay valid throughout that cycle.
- Length check: decided on the edge accepting length byte 4. In S_ERR `rx_ready` is 0 from the next cycle.
- Checksum: decided on the edge accepting the checksum byte.
  - On a match, `cpu_reset` falls and `done` rises on the next cycle, the same cycle for both.
  - On a mismatch, `error` rises on the next cycle.
- Last data word: its write strobe and the S_CSUM state occur in the same cycle, so the checksum byte can be accepted in that cycle.
- `reset` mid-frame aborts the load on that edge. Any write strobe pending for that edge is dropped, and the loader restarts at S_LEN.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t` (S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR).
  - `LEN_BYTES`=4.
  - `WORD_BYTES`=4.
- Sub-module `word_packer`:
  - 32-bit little-endian byte shifter plus the 2-bit byte counter.
  - Outputs `word` and a one-cycle `word_valid` when the 4th byte is accepted.
  - Used for both the length field and the data words.
- The top level holds the FSM, the word index, the running XOR and the output registers.

## Test plan
- Normal load, DEPTH_WORDS=1024:
  - Stream 02 00 00 00 | 93 00 50 00 | 13 81 10 00 | 43.
  - Required: two write strobes, addr 0x0 / data 0x00500093, then addr 0x4 / data 0x00108113.
  - Then `done`=1 and `cpu_reset`=0, with `error` staying 0.
- Zero length: stream 00 00 00 00 | 00 → no `imem_we`; `done`=1 one cycle after the checksum byte.
- Oversize length: stream 01 04 00 00 (N=1025) → `error`=1, `rx_ready`=0, `cpu_reset`=1; no writes; further bytes ignored.
- Bad checksum: the normal-load stream with a final byte of 44 → both words are written, then `error`=1, `cpu_reset` stays 1, `done` stays 0.
- Flow control: the normal-load stream with `rx_valid` dropped for 3 cycles between every byte → identical writes and final state; no byte is double-counted.
- Reset mid-load:
  - Assert `reset` after byte 6 of the normal stream → all outputs return to their reset values.
  - A full normal stream sent afterwards loads correctly, with its first write at addr 0x0.
